io_uart0: RTL and testbench

Memory-mapped serial console output port for the cpu0 system. It sits on the CPU memory bus beside memory0 and claims stores to IOADDR (0x10000). It unpacks the stored word into bytes, buffers them in a FIFO, and shifts them out as 8N1 UART frames. A status/control register at IOADDR+4 lets firmware poll for space and enable a transmit-idle interrupt.

---
 rtl/cpu0_pkg.sv | 28 ++
 rtl/io_uart0_if.sv | 14 +
 rtl/io_fifo0.sv | 58 +++++
 rtl/io_uart0.sv | 239 +++++++++++++++++++++++
 tb/tb_io_uart0.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu0_pkg.sv
// Shared definitions for the cpu0 system: bus access sizes, the console
// port address, the UART transmitter states and status bit positions.
package cpu0_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE  = 2'b00,
        SZ_INT16 = 2'b01,
        SZ_INT24 = 2'b10,
        SZ_INT32 = 2'b11
    } msize_e;

    localparam logic [31:0] IOADDR = 32'h0001_0000;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_e;

    localparam int unsigned ST_TX_BUSY     = 0;
    localparam int unsigned ST_FIFO_FULL   = 1;
    localparam int unsigned ST_OVF         = 2;
    localparam int unsigned ST_IE          = 3;
    localparam int unsigned ST_UNPACK_BUSY = 4;
    localparam int unsigned ST_COUNT_LSB   = 8;

endpackage

// File: rtl/io_uart0_if.sv
// CPU memory-bus request signals as seen by the console port.
// Read data is returned on a separate tristate port of the slave.
interface io_uart0_if;

    logic        en;
    logic        rw;
    logic [1:0]  m_size;
    logic [31:0] abus;
    logic [31:0] dbus_in;

    modport master (output en, rw, m_size, abus, dbus_in);
    modport slave  (input  en, rw, m_size, abus, dbus_in);

endinterface

// File: rtl/io_fifo0.sv
// Synchronous FIFO with extra-MSB pointers. A push while full is accepted
// only when a pop happens on the same edge; a pop while empty is ignored,
// so a simultaneous push into an empty FIFO just writes.
module io_fifo0 #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 8,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    localparam logic [AW:0] PTR_ONE = 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_q, wr_d;
    logic [AW:0]      rd_q, rd_d;
    logic             do_push, do_pop;

    assign empty   = (wr_q == rd_q);
    assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign count   = wr_q - rd_q;
    assign dout    = mem_q[rd_q[AW-1:0]];
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;

    // Pointer advance for accepted pushes and pops.
    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (do_push) wr_d = wr_q + PTR_ONE;
        if (do_pop)  rd_d = rd_q + PTR_ONE;
    end

    // Pointer registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    // Storage write; contents need no reset.
    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/io_uart0.sv
// Memory-mapped console output: unpacks stored words into bytes, queues
// them and shifts them out as back-to-back 8N1 frames. A status/control
// register one word above the data port exposes FIFO state, overflow and
// the transmit-idle interrupt enable.
module io_uart0 #(
    parameter logic [31:0] IOADDR       = cpu0_pkg::IOADDR,
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned FIFO_DEPTH   = 16
) (
    input  logic        clock,
    input  logic        reset,
    io_uart0_if.slave   bus,
    output logic [31:0] dbus_out,
    output logic        txd,
    output logic        irq
);

    import cpu0_pkg::*;

    localparam int unsigned BW        = $clog2(CLKS_PER_BIT);
    localparam int unsigned CW        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BAUD_ONE  = 1;
    localparam logic [31:0] CTRL_ADDR   = IOADDR + 32'd4;

    // Bus decode
    logic   wr_data, wr_ctrl, rd_stat;
    msize_e size_in;

    assign wr_data = bus.en && !bus.rw && (bus.abus == IOADDR);
    assign wr_ctrl = bus.en && !bus.rw && (bus.abus == CTRL_ADDR);
    assign rd_stat = bus.en &&  bus.rw && (bus.abus == CTRL_ADDR);
    assign size_in = msize_e'(bus.m_size);

    // Unpacker: a mask of lanes still to be pushed, lowest first
    logic [31:0] word_q, word_d;
    logic [3:0]  lanes_q, lanes_d, lanes_new, lane_sel;
    logic [7:0]  push_byte;
    logic        push, unpack_last, accept, drop_wr;

    // A write landing on the edge that pushes the final lane is accepted,
    // so stores spaced four clocks apart always chain without loss.
    assign unpack_last = ((lanes_q & (lanes_q - 4'd1)) == 4'd0);
    assign accept      = wr_data && unpack_last;
    assign drop_wr     = wr_data && !unpack_last;
    assign push        = |lanes_q;

    // Lanes to queue for an incoming store; zero lanes are skipped up front.
    always_comb begin
        lanes_new = '0;
        case (size_in)
            SZ_BYTE: lanes_new = 4'b0001;
            default: begin
                if (bus.dbus_in[7:0] != 8'h00) begin
                    lanes_new[0] = 1'b1;
                    lanes_new[1] = (bus.dbus_in[15:8] != 8'h00);
                    lanes_new[2] = (size_in != SZ_INT16) && (bus.dbus_in[23:16] != 8'h00);
                    lanes_new[3] = (size_in == SZ_INT32) && (bus.dbus_in[31:24] != 8'h00);
                end
            end
        endcase
    end

    // Pick the lowest pending lane as this clock's push.
    always_comb begin
        lane_sel  = '0;
        push_byte = '0;
        if (lanes_q[0]) begin
            lane_sel  = 4'b0001;
            push_byte = word_q[7:0];
        end else if (lanes_q[1]) begin
            lane_sel  = 4'b0010;
            push_byte = word_q[15:8];
        end else if (lanes_q[2]) begin
            lane_sel  = 4'b0100;
            push_byte = word_q[23:16];
        end else if (lanes_q[3]) begin
            lane_sel  = 4'b1000;
            push_byte = word_q[31:24];
        end
    end

    // Unpacker next state: load on acceptance, else retire the pushed lane.
    always_comb begin
        lanes_d = lanes_q & ~lane_sel;
        word_d  = word_q;
        if (accept) begin
            lanes_d = lanes_new;
            word_d  = bus.dbus_in;
        end
    end

    // Byte FIFO
    logic          pop, fifo_full, fifo_empty;
    logic [7:0]    fifo_dout;
    logic [CW-1:0] fifo_count;

    io_fifo0 #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (push_byte),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Transmitter
    tx_state_e     state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          baud_last;

    assign baud_last = (baud_q == BAUD_LAST);

    // Frame sequencing; STOP chains straight into START when data waits.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        case (state_q)
            TX_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_dout;
                    baud_d  = '0;
                    state_d = TX_START;
                end
            end
            TX_START: begin
                if (baud_last) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = TX_DATA;
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end
            TX_DATA: begin
                if (baud_last) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) state_d = TX_STOP;
                    else               bit_d   = bit_q + 3'd1;
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end
            TX_STOP: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = fifo_dout;
                        state_d = TX_START;
                    end else begin
                        state_d = TX_IDLE;
                    end
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end
            default: state_d = TX_IDLE;
        endcase
    end

    // Line level follows the state directly so reset idles the line at once.
    always_comb begin
        txd = 1'b1;
        case (state_q)
            TX_START: txd = 1'b0;
            TX_DATA:  txd = shift_q[0];
            default:  txd = 1'b1;
        endcase
    end

    // Control/status registers
    logic ovf_q, ovf_d, ie_q, ie_d, irq_q, irq_d;

    // Overflow is sticky; a new drop wins over a same-cycle clear.
    always_comb begin
        ovf_d = ovf_q;
        if (wr_ctrl && bus.dbus_in[2]) ovf_d = 1'b0;
        if (drop_wr || (push && fifo_full && !pop)) ovf_d = 1'b1;
        ie_d  = wr_ctrl ? bus.dbus_in[3] : ie_q;
        irq_d = ie_q && fifo_empty && (state_q == TX_IDLE);
    end

    // All sequential state, cleared asynchronously.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            word_q  <= '0;
            lanes_q <= '0;
            state_q <= TX_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            ovf_q   <= 1'b0;
            ie_q    <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            word_q  <= word_d;
            lanes_q <= lanes_d;
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            ovf_q   <= ovf_d;
            ie_q    <= ie_d;
            irq_q   <= irq_d;
        end
    end

    assign irq = irq_q;

    // Status word, driven onto the bus only for a status read.
    logic [31:0] status;

    always_comb begin
        status                        = '0;
        status[ST_TX_BUSY]            = (state_q != TX_IDLE);
        status[ST_FIFO_FULL]          = fifo_full;
        status[ST_OVF]                = ovf_q;
        status[ST_IE]                 = ie_q;
        status[ST_UNPACK_BUSY]        = push;
        status[ST_COUNT_LSB +: 8]     = 8'(fifo_count);
    end

    assign dbus_out = rd_stat ? status : 'z;

endmodule

// File: tb/tb_io_uart0.sv
// Randomised bench for io_uart0 against a frame-timing reference model.
// Undriven read data is pulled high, so a released bus reads all-ones.
module tb_io_uart0;

    import cpu0_pkg::*;

    localparam int unsigned CPB    = 4;
    localparam int unsigned DEPTH  = 16;
    localparam logic [31:0] DATA_A = 32'h0001_0000;
    localparam logic [31:0] STAT_A = 32'h0001_0004;
    localparam logic [31:0] BUS_Z  = 32'hFFFF_FFFF;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic txd, irq;
    tri1 [31:0] dbus_out;

    io_uart0_if bus ();

    io_uart0 #(
        .IOADDR       (DATA_A),
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .bus      (bus),
        .dbus_out (dbus_out),
        .txd      (txd),
        .irq      (irq)
    );

    always #5 clock = ~clock;

    // Reference model state
    logic [7:0] m_fifo[$];
    logic [7:0] m_unpack[$];
    logic [7:0] m_txbyte;
    int         m_cyc;
    int         m_start;
    bit         m_active, m_ovf, m_ie, m_irq;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_fifo.delete();
        m_unpack.delete();
        m_active = 0;
        m_ovf    = 0;
        m_ie     = 0;
        m_irq    = 0;
    endtask

    // Line level from time elapsed since the frame's pop edge.
    function automatic logic model_txd();
        int idx;
        if (!m_active) return 1'b1;
        idx = (m_cyc - m_start) / CPB;
        if (idx == 0) return 1'b0;
        if (idx <= 8) return m_txbyte[idx-1];
        return 1'b1;
    endfunction

    function automatic logic [31:0] model_status();
        logic [31:0] s;
        s       = '0;
        s[0]    = m_active;
        s[1]    = (m_fifo.size() == DEPTH);
        s[2]    = m_ovf;
        s[3]    = m_ie;
        s[4]    = (m_unpack.size() != 0);
        s[15:8] = 8'(m_fifo.size());
        return s;
    endfunction

    // One rising edge of the reference, using the bus inputs as driven.
    task automatic model_step();
        int          pre_un, n;
        bit          pre_empty, pre_full, done, popped, set_ovf, irq_next;
        logic [7:0]  b;
        logic [31:0] d;
        m_cyc++;
        pre_empty = (m_fifo.size() == 0);
        pre_full  = (m_fifo.size() == DEPTH);
        pre_un    = m_unpack.size();
        set_ovf   = 0;
        irq_next  = m_ie && pre_empty && !m_active;
        done      = m_active && ((m_cyc - m_start) == 10 * CPB);
        popped    = 0;
        if ((!m_active || done) && !pre_empty) begin
            m_txbyte = m_fifo.pop_front();
            m_start  = m_cyc;
            m_active = 1;
            popped   = 1;
        end else if (done) begin
            m_active = 0;
        end
        if (pre_un > 0) begin
            b = m_unpack.pop_front();
            if (pre_full && !popped) set_ovf = 1;
            else m_fifo.push_back(b);
        end
        d = bus.dbus_in;
        if (bus.en && !bus.rw && bus.abus == DATA_A) begin
            if (pre_un > 1) begin
                set_ovf = 1;
            end else begin
                n = int'(bus.m_size);
                if (n == 0) begin
                    m_unpack.push_back(d[7:0]);
                end else if (d[7:0] != 8'h00) begin
                    m_unpack.push_back(d[7:0]);
                    for (int k = 1; k <= n; k++)
                        if (d[8*k +: 8] != 8'h00) m_unpack.push_back(d[8*k +: 8]);
                end
            end
        end
        if (bus.en && !bus.rw && bus.abus == STAT_A) begin
            m_ie = d[3];
            if (d[2]) m_ovf = 0;
        end
        if (set_ovf) m_ovf = 1;
        m_irq = irq_next;
    endtask

    task automatic cycle();
        @(posedge clock);
        model_step();
        @(negedge clock);
        bus.en = 1'b0;
        chk("txd", 32'(txd), 32'(model_txd()));
        chk("irq", 32'(irq), 32'(m_irq));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
        bus.en      = 1'b1;
        bus.rw      = 1'b0;
        bus.abus    = a;
        bus.dbus_in = d;
        bus.m_size  = sz;
        cycle();
    endtask

    task automatic rd_stat();
        bus.en   = 1'b1;
        bus.rw   = 1'b1;
        bus.abus = STAT_A;
        #1;
        chk("status", dbus_out, model_status());
        cycle();
    endtask

    task automatic rd_z(input logic [31:0] a);
        bus.en   = 1'b1;
        bus.rw   = 1'b1;
        bus.abus = a;
        #1;
        chk("read_z", dbus_out, BUS_Z);
        cycle();
    endtask

    function automatic logic [7:0] rand_lane();
        if ($urandom_range(0, 3) == 0) return 8'h00;
        return 8'($urandom_range(1, 255));
    endfunction

    initial begin
        logic [31:0] d;
        int          op;
        bus.en = 1'b0; bus.rw = 1'b0; bus.m_size = 2'b00;
        bus.abus = '0; bus.dbus_in = '0;
        m_cyc = 0; m_start = 0; m_txbyte = '0;
        model_reset();

        // Reset values
        #12;
        chk("rst_txd", 32'(txd), 32'd1);
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_bus", dbus_out, BUS_Z);
        @(negedge clock);
        reset = 1'b1;
        rd_stat();

        // Single byte, then interrupt enable once idle
        wr(DATA_A, 32'h0000_0041, SZ_BYTE);
        idle(44);
        wr(STAT_A, 32'h0000_0008, SZ_INT32);
        idle(3);

        // Packed word with zero top lane, then a word with zero lane0
        wr(DATA_A, 32'h0043_4241, SZ_INT32);
        idle(5);
        rd_stat();
        idle(130);
        wr(DATA_A, 32'h4400_4200, SZ_INT32);
        idle(2);
        rd_stat();
        rd_z(32'h0001_0008);
        rd_z(DATA_A);

        // FIFO overflow while a frame holds the line, then clear ovf
        wr(DATA_A, 32'h0000_0055, SZ_BYTE);
        idle(3);
        for (int i = 0; i < 17; i++) wr(DATA_A, 32'h60 + i, SZ_BYTE);
        rd_stat();
        wr(STAT_A, 32'h0000_0004, SZ_INT32);
        rd_stat();
        idle(700);

        // Second store while the unpacker is still busy
        wr(DATA_A, 32'h0403_0201, SZ_INT32);
        wr(DATA_A, 32'h0807_0605, SZ_INT32);
        rd_stat();
        idle(170);
        wr(STAT_A, 32'h0000_0004, SZ_INT32);

        // Asynchronous reset in the middle of the data bits
        wr(DATA_A, 32'h0000_00A5, SZ_BYTE);
        idle(2 + 3 * CPB);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        chk("arst_txd", 32'(txd), 32'd1);
        chk("arst_irq", 32'(irq), 32'd0);
        bus.en = 1'b1; bus.rw = 1'b1; bus.abus = STAT_A;
        #1;
        chk("arst_stat", dbus_out, 32'd0);
        bus.en = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        wr(DATA_A, 32'h0000_003C, SZ_BYTE);
        idle(45);

        // Randomised mix of stores, reads and control writes
        for (int it = 0; it < 250; it++) begin
            op = $urandom_range(0, 9);
            if (op <= 4) begin
                d = {rand_lane(), rand_lane(), rand_lane(), rand_lane()};
                wr(DATA_A, d, 2'($urandom_range(0, 3)));
            end else if (op <= 6) begin
                rd_stat();
            end else if (op == 7) begin
                wr(STAT_A, $urandom, SZ_INT32);
            end else if (op == 8) begin
                rd_z(($urandom_range(0, 1) == 0) ? DATA_A : 32'h0001_0008);
            end
            idle($urandom_range(0, 5));
        end

        // Drain with a bounded budget, then watch the idle interrupt
        wr(STAT_A, 32'h0000_000C, SZ_INT32);
        for (int i = 0; i < 2000; i++) begin
            if (!m_active && m_fifo.size() == 0 && m_unpack.size() == 0) break;
            cycle();
        end
        idle(3);
        rd_stat();
        chk("final_irq", 32'(irq), 32'd1);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
